bkg_fetch_arbiter: RTL

Sequences reads from the single-port, 1-cycle-latency background image RAM (80x96 texels, 24-bit RGB, 7680 words). Generates texel addresses for the VGA pixel pipeline, with 8x horizontal and 5x vertical upscaling and a frame-latched vertical scroll with wrap-around. Lends idle RAM cycles to an auxiliary requester, such as the collision or colour sampler, through a req/ack handshake. Sits between the VGA timing/draw logic and the background RAM.

---
 rtl/bkg_fetch_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bkg_fetch_arbiter.sv
// Background RAM read sequencer: upscaled, vertically scrolled texel fetch for the
// pixel pipeline, with idle RAM cycles lent to an auxiliary requester.
module bkg_fetch_arbiter #(
  parameter int IMG_W   = 80,
  parameter int IMG_H   = 96,
  parameter int X_SCALE = 8,
  parameter int Y_SCALE = 5,
  parameter int DEPTH   = IMG_W * IMG_H
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        line_start,
  input  logic        pix_en,
  input  logic [6:0]  scroll_in,
  input  logic        scroll_we,
  input  logic        aux_req,
  input  logic [12:0] aux_addr,
  output logic        aux_ack,
  output logic [23:0] aux_data,
  output logic        aux_valid,
  output logic [12:0] ram_rd_addr,
  input  logic [23:0] ram_data,
  output logic [23:0] pix_data,
  output logic        pix_valid
);

  localparam int AW = 13;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int XW = $clog2(X_SCALE);
  localparam int YW = $clog2(Y_SCALE);

  logic [6:0]    scroll_pending_reg, scroll_pending_next;
  logic [6:0]    scroll_active_reg, scroll_active_next;
  logic [6:0]    scroll_wr;
  logic [CW-1:0] col_idx_reg, col_idx_next;
  logic [XW-1:0] col_sub_reg, col_sub_next;
  logic [RW-1:0] row_idx_reg, row_idx_next;
  logic [YW-1:0] row_sub_reg, row_sub_next;
  logic [AW-1:0] row_base_reg, row_base_next;
  logic          first_line_reg, first_line_next;
  logic [AW-1:0] addr_hold_reg;
  logic [AW-1:0] pix_addr;
  logic [AW-1:0] aux_fold;
  logic          pix_valid_reg, aux_valid_reg;

  // Counter updates are applied in order frame -> line -> pixel, so a coincident
  // pix_en sees the post-update position.
  always_comb begin
    scroll_wr           = (scroll_in >= 7'(IMG_H)) ? scroll_in - 7'(IMG_H) : scroll_in;
    scroll_pending_next = scroll_we ? scroll_wr : scroll_pending_reg;
    scroll_active_next  = frame_start ? scroll_pending_next : scroll_active_reg;
    col_idx_next        = col_idx_reg;
    col_sub_next        = col_sub_reg;
    row_idx_next        = row_idx_reg;
    row_sub_next        = row_sub_reg;
    row_base_next       = row_base_reg;
    first_line_next     = first_line_reg;

    if (frame_start) begin
      row_idx_next    = RW'(scroll_active_next);
      row_base_next   = AW'(scroll_active_next) * AW'(IMG_W);
      row_sub_next    = '0;
      first_line_next = 1'b1;
    end

    if (line_start) begin
      col_idx_next = '0;
      col_sub_next = '0;
      if (first_line_next) begin
        first_line_next = 1'b0;
      end else if (row_sub_next == YW'(Y_SCALE - 1)) begin
        row_sub_next = '0;
        if (row_idx_next == RW'(IMG_H - 1)) begin
          row_idx_next  = '0;
          row_base_next = '0;
        end else begin
          row_idx_next  = row_idx_next + 1'b1;
          row_base_next = row_base_next + AW'(IMG_W);
        end
      end else begin
        row_sub_next = row_sub_next + 1'b1;
      end
    end

    pix_addr = row_base_next + AW'(col_idx_next);

    if (pix_en) begin
      if (col_sub_next == XW'(X_SCALE - 1)) begin
        col_sub_next = '0;
        if (col_idx_next != CW'(IMG_W - 1))
          col_idx_next = col_idx_next + 1'b1;
      end else begin
        col_sub_next = col_sub_next + 1'b1;
      end
    end
  end

  // Pixel reads always win; aux is granted only in cycles without pix_en.
  always_comb begin
    aux_fold    = (aux_addr >= AW'(DEPTH)) ? aux_addr - AW'(DEPTH) : aux_addr;
    aux_ack     = 1'b0;
    ram_rd_addr = addr_hold_reg;
    if (rst) begin
      ram_rd_addr = '0;
    end else if (pix_en) begin
      ram_rd_addr = pix_addr;
    end else if (aux_req) begin
      aux_ack     = 1'b1;
      ram_rd_addr = aux_fold;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scroll_pending_reg <= '0;
      scroll_active_reg  <= '0;
      col_idx_reg        <= '0;
      col_sub_reg        <= '0;
      row_idx_reg        <= '0;
      row_sub_reg        <= '0;
      row_base_reg       <= '0;
      first_line_reg     <= 1'b0;
      addr_hold_reg      <= '0;
      pix_valid_reg      <= 1'b0;
      aux_valid_reg      <= 1'b0;
    end else begin
      scroll_pending_reg <= scroll_pending_next;
      scroll_active_reg  <= scroll_active_next;
      col_idx_reg        <= col_idx_next;
      col_sub_reg        <= col_sub_next;
      row_idx_reg        <= row_idx_next;
      row_sub_reg        <= row_sub_next;
      row_base_reg       <= row_base_next;
      first_line_reg     <= first_line_next;
      addr_hold_reg      <= ram_rd_addr;
      pix_valid_reg      <= pix_en;
      aux_valid_reg      <= aux_ack;
    end
  end

  assign pix_valid = pix_valid_reg;
  assign aux_valid = aux_valid_reg;
  assign pix_data  = pix_valid_reg ? ram_data : '0;
  assign aux_data  = aux_valid_reg ? ram_data : '0;

endmodule
